// File: rtl/isq_sel_arb_pkg.sv
// Shared definitions for the issue-queue select/grant scheduler.
// Holds the queue geometry, function-unit class codes, unit bit positions
// and a one-hot helper used by the arbiter.
package isq_sel_arb_pkg;
    localparam int ISQ_DEPTH        = 64;
    localparam int ISQ_IDX_BITS_NUM = 6;
    localparam int FU_CLS_BITS      = 2;
    localparam int NUM_UNITS        = 4;

    typedef enum logic [FU_CLS_BITS-1:0] {
        CLS_MULT = 2'b00,
        CLS_ALU  = 2'b01,
        CLS_ADDR = 2'b10,
        CLS_NONE = 2'b11
    } fu_cls_e;

    localparam int UNIT_MULT = 0;
    localparam int UNIT_ALU1 = 1;
    localparam int UNIT_ALU2 = 2;
    localparam int UNIT_ADDR = 3;

    function automatic logic [ISQ_DEPTH-1:0] idx_onehot(input logic [ISQ_IDX_BITS_NUM-1:0] idx);
        logic [ISQ_DEPTH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/isq_sel_arb_if.sv
// Issue-queue <-> scheduler bundle.
//   req_rdy / req_cls / head_idx : per-line ready, class and age origin
//   fun_rdy_frm_exe              : unit can accept (MULT, ALU1, ALU2, ADDR)
//   fls_vld                      : ROB flush
//   gnt_vld / gnt_idx            : registered grants per unit
//   clr_inst_wat                 : per-line clear-wait pulse
//   mul_bsy                      : multiplier interval still running
// master = queue/exe side, slave = scheduler.
interface isq_sel_arb_if;
    import isq_sel_arb_pkg::*;

    logic [ISQ_DEPTH-1:0]                    req_rdy;
    logic [FU_CLS_BITS*ISQ_DEPTH-1:0]        req_cls;
    logic [ISQ_IDX_BITS_NUM-1:0]             head_idx;
    logic [NUM_UNITS-1:0]                    fun_rdy_frm_exe;
    logic                                    fls_vld;
    logic [NUM_UNITS-1:0]                    gnt_vld;
    logic [NUM_UNITS*ISQ_IDX_BITS_NUM-1:0]   gnt_idx;
    logic [ISQ_DEPTH-1:0]                    clr_inst_wat;
    logic                                    mul_bsy;

    modport master (
        output req_rdy, req_cls, head_idx, fun_rdy_frm_exe, fls_vld,
        input  gnt_vld, gnt_idx, clr_inst_wat, mul_bsy
    );

    modport slave (
        input  req_rdy, req_cls, head_idx, fun_rdy_frm_exe, fls_vld,
        output gnt_vld, gnt_idx, clr_inst_wat, mul_bsy
    );
endinterface

// File: rtl/isq_sel_arb_age_pri_enc.sv
// Age-ordered priority encoder (combinational).
// Finds the request line closest to i_head going upward with wrap, i.e. the
// oldest line when ages are measured from the queue head.
//   i_req  : request vector, one bit per queue line
//   i_head : age origin
//   o_vld  : at least one request present
//   o_idx  : absolute index of the oldest request
module age_pri_enc
    import isq_sel_arb_pkg::*;
(
    input  logic [ISQ_DEPTH-1:0]        i_req,
    input  logic [ISQ_IDX_BITS_NUM-1:0] i_head,
    output logic                        o_vld,
    output logic [ISQ_IDX_BITS_NUM-1:0] o_idx
);
    logic [ISQ_DEPTH-1:0]        w_rot;
    logic [ISQ_IDX_BITS_NUM-1:0] w_ffs;

    // Rotate right by head: w_rot[j] is the line of age j. The 6-bit index
    // sum wraps modulo the queue depth.
    always_comb begin
        w_rot = '0;
        for (int j = 0; j < ISQ_DEPTH; j++) begin
            w_rot[j] = i_req[ISQ_IDX_BITS_NUM'(j) + i_head];
        end
    end

    // Scan from the youngest down so the lowest set age wins.
    always_comb begin
        o_vld = 1'b0;
        w_ffs = '0;
        for (int j = ISQ_DEPTH - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                o_vld = 1'b1;
                w_ffs = ISQ_IDX_BITS_NUM'(j);
            end
        end
    end

    assign o_idx = w_ffs + i_head;
endmodule

// File: rtl/isq_sel_arb.sv
// Select/grant scheduler between the 64-line issue queue and the four
// function units (MULT, ALU1, ALU2, ADDR).
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active-high
//   io_bus : isq_sel_arb_if slave (requests in, grants out)
// Picks the oldest eligible line per unit class each cycle, registers the
// grants, pulses clear-wait for granted lines and enforces the multiplier
// initiation interval. A flush suppresses selection for that cycle.
module isq_sel_arb
    import isq_sel_arb_pkg::*;
#(
    parameter int MUL_II       = 3,
    parameter int MUL_CNT_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    isq_sel_arb_if.slave     io_bus
);
    localparam logic [MUL_CNT_BITS-1:0] MUL_LOAD = MUL_CNT_BITS'(MUL_II - 1);

    logic [ISQ_DEPTH-1:0]        r_pend_msk;
    logic [ISQ_DEPTH-1:0]        r_clr;
    logic [NUM_UNITS-1:0]        r_gnt_vld;
    logic [ISQ_IDX_BITS_NUM-1:0] r_gnt_idx [NUM_UNITS];
    logic [MUL_CNT_BITS-1:0]     r_mul_cnt;

    logic [ISQ_DEPTH-1:0]        w_elig, w_mul_req, w_alu_req, w_alu2_req, w_addr_req, w_clr;
    logic                        w_mul_vld, w_alu1_vld, w_alu2_vld, w_addr_vld;
    logic [ISQ_IDX_BITS_NUM-1:0] w_mul_idx, w_alu1_idx, w_alu2_idx, w_addr_idx;
    logic                        w_alu1_gnt;
    logic [NUM_UNITS-1:0]        w_gnt_vld;
    logic [ISQ_IDX_BITS_NUM-1:0] w_gnt_idx [NUM_UNITS];

    // Lines granted last cycle are still marked ready until the queue clears them.
    assign w_elig = io_bus.req_rdy & ~r_pend_msk;

    always_comb begin
        w_mul_req  = '0;
        w_alu_req  = '0;
        w_addr_req = '0;
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            w_mul_req[i]  = w_elig[i] & (io_bus.req_cls[FU_CLS_BITS*i +: FU_CLS_BITS] == CLS_MULT);
            w_alu_req[i]  = w_elig[i] & (io_bus.req_cls[FU_CLS_BITS*i +: FU_CLS_BITS] == CLS_ALU);
            w_addr_req[i] = w_elig[i] & (io_bus.req_cls[FU_CLS_BITS*i +: FU_CLS_BITS] == CLS_ADDR);
        end
    end

    age_pri_enc u_enc_mul  (.i_req(w_mul_req),  .i_head(io_bus.head_idx), .o_vld(w_mul_vld),  .o_idx(w_mul_idx));
    age_pri_enc u_enc_alu1 (.i_req(w_alu_req),  .i_head(io_bus.head_idx), .o_vld(w_alu1_vld), .o_idx(w_alu1_idx));
    age_pri_enc u_enc_alu2 (.i_req(w_alu2_req), .i_head(io_bus.head_idx), .o_vld(w_alu2_vld), .o_idx(w_alu2_idx));
    age_pri_enc u_enc_addr (.i_req(w_addr_req), .i_head(io_bus.head_idx), .o_vld(w_addr_vld), .o_idx(w_addr_idx));

    assign w_alu1_gnt = w_alu1_vld & io_bus.fun_rdy_frm_exe[UNIT_ALU1] & ~io_bus.fls_vld;

    // ALU2 only skips ALU1's pick when ALU1 actually takes it; a stalled
    // ALU1 leaves the oldest ALU line to ALU2.
    assign w_alu2_req = w_alu_req & ~(w_alu1_gnt ? idx_onehot(w_alu1_idx) : '0);

    always_comb begin
        w_gnt_vld[UNIT_MULT] = w_mul_vld & io_bus.fun_rdy_frm_exe[UNIT_MULT]
                               & (r_mul_cnt == '0) & ~io_bus.fls_vld;
        w_gnt_vld[UNIT_ALU1] = w_alu1_gnt;
        w_gnt_vld[UNIT_ALU2] = w_alu2_vld & io_bus.fun_rdy_frm_exe[UNIT_ALU2] & ~io_bus.fls_vld;
        w_gnt_vld[UNIT_ADDR] = w_addr_vld & io_bus.fun_rdy_frm_exe[UNIT_ADDR] & ~io_bus.fls_vld;
        w_gnt_idx[UNIT_MULT] = w_mul_idx;
        w_gnt_idx[UNIT_ALU1] = w_alu1_idx;
        w_gnt_idx[UNIT_ALU2] = w_alu2_idx;
        w_gnt_idx[UNIT_ADDR] = w_addr_idx;
        w_clr = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (w_gnt_vld[k]) w_clr = w_clr | idx_onehot(w_gnt_idx[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt_vld  <= '0;
            r_clr      <= '0;
            r_pend_msk <= '0;
            r_mul_cnt  <= '0;
            for (int k = 0; k < NUM_UNITS; k++) r_gnt_idx[k] <= '0;
        end else begin
            r_gnt_vld  <= w_gnt_vld;
            r_clr      <= w_clr;
            // w_clr is already zero during a flush, so this also clears the mask.
            r_pend_msk <= w_clr;
            for (int k = 0; k < NUM_UNITS; k++) begin
                if (w_gnt_vld[k]) r_gnt_idx[k] <= w_gnt_idx[k];
            end
            if (io_bus.fls_vld)
                r_mul_cnt <= '0;
            else if (w_gnt_vld[UNIT_MULT])
                r_mul_cnt <= MUL_LOAD;
            else if (r_mul_cnt != '0)
                r_mul_cnt <= r_mul_cnt - 1'b1;
        end
    end

    always_comb begin
        io_bus.gnt_idx = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            io_bus.gnt_idx[ISQ_IDX_BITS_NUM*k +: ISQ_IDX_BITS_NUM] = r_gnt_idx[k];
        end
    end

    assign io_bus.gnt_vld      = r_gnt_vld;
    assign io_bus.clr_inst_wat = r_clr;
    assign io_bus.mul_bsy      = (r_mul_cnt != '0);
endmodule
